parity_checker: RTL

Bit-serial receive-side parity checker, the counterpart of the 16-bit parity generator. Accepts LSB-first frames of DATA_W data bits followed by one parity bit, reassembles the word, checks parity, and presents word plus error flag on a valid/ready output with a one-entry holding register. Sits between a serial link front end and the word-level consumer. Keeps a saturating parity-error counter.

---
 rtl/parity_pkg.sv | 20 ++
 rtl/parity_reduce.sv | 16 +
 rtl/parity_checker.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and helpers for the parity checker/generator pair
package parity_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2
   } state_e;

   localparam logic EVEN = 1'b0;
   localparam logic ODD  = 1'b1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/parity_reduce.sv
// rtl/parity_reduce.sv - XOR reduction over a word, inverted for odd parity
module parity_reduce
   import parity_pkg::*;
#(
   parameter int W          = 16,
   parameter int ODD_PARITY = 0
) (
   input  logic [W-1:0] data,
   output logic         par
);

   localparam logic INV = (ODD_PARITY != 0) ? ODD : EVEN;

   assign par = (^data) ^ INV;

endmodule

// File: rtl/parity_checker.sv
// rtl/parity_checker.sv - bit-serial receive parity checker with holding register
// Optional error counter enabled by defining PARITY_CHECKER_ERRCNT_EN.
module parity_checker
   import parity_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int CNT_W      = 16,
   parameter int ODD_PARITY = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sin_valid,
   input  logic              sin_bit,
   input  logic              sin_sof,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_perr,
   output logic              out_ovf,
   input  logic              err_cnt_clr,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam int IDX_W = (clog2(DATA_W) < 1) ? 1 : clog2(DATA_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              perr_q, perr_d;
   logic              ovf_q, ovf_d;
   logic              data_par;
   logic              frame_done;
   logic              frame_perr;

   // In PAR the shift register already holds every data bit of the frame.
   parity_reduce #(
      .W          (DATA_W),
      .ODD_PARITY (ODD_PARITY)
   ) u_reduce (
      .data (shreg_q),
      .par  (data_par)
   );

   assign frame_perr = data_par ^ sin_bit;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      shreg_d    = shreg_q;
      frame_done = 1'b0;
      if (sin_valid) begin
         if (sin_sof) begin
            shreg_d[0] = sin_bit;
            idx_d      = IDX_W'(1);
            state_d    = (DATA_W == 1) ? PAR : DATA;
         end else begin
            case (state_q)
               DATA: begin
                  shreg_d[idx_q] = sin_bit;
                  idx_d          = idx_q + IDX_W'(1);
                  if (idx_q == IDX_LAST) state_d = PAR;
               end
               PAR: begin
                  frame_done = 1'b1;
                  idx_d      = '0;
                  state_d    = IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      valid_d = valid_q & ~out_ready;
      data_d  = data_q;
      perr_d  = perr_q;
      ovf_d   = 1'b0;
      if (frame_done) begin
         if (!valid_q || out_ready) begin
            valid_d = 1'b1;
            data_d  = shreg_q;
            perr_d  = frame_perr;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_perr  = perr_q;
   assign out_ovf   = ovf_q;

`ifdef PARITY_CHECKER_ERRCNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Dropped frames still count; clear beats a same-cycle increment.
   always_comb begin
      cnt_d = cnt_q;
      if (frame_done && frame_perr && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
      if (err_cnt_clr) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign err_cnt = cnt_q;
`else
   logic unused_err_cnt_clr;
   assign unused_err_cnt_clr = err_cnt_clr;
   assign err_cnt            = '0;
`endif

endmodule
